// File: rtl/ddr4_v2_2_20_carry_or_pipe.sv
// Pipelined wide OR/AND reduction: one segment is folded per stage, with a global-enable stall
// and an optional per-burst accumulate that is closed by S_LAST.
module ddr4_v2_2_20_carry_or_pipe #(
   parameter     C_FAMILY    = "rtl",
   parameter int C_WIDTH     = 32,
   parameter int C_SEG_WIDTH = 8,
   parameter int C_MODE      = 0,
   parameter int C_ACCUM     = 0
) (
   input  logic               ACLK,
   input  logic               ARESET,
   input  logic [C_WIDTH-1:0] S_DATA,
   input  logic               S_LAST,
   input  logic               S_VALID,
   output logic               S_READY,
   output logic               M_RESULT,
   output logic               M_VALID,
   input  logic               M_READY
);

   localparam int   NSTAGE = (C_WIDTH + C_SEG_WIDTH - 1) / C_SEG_WIDTH;
   localparam int   PAD_W  = NSTAGE * C_SEG_WIDTH;
   localparam logic IDENT  = (C_MODE != 0);

   function automatic logic red_seg(input logic carry, input logic [C_SEG_WIDTH-1:0] seg);
      if (C_MODE != 0) return carry & (&seg);
      else             return carry | (|seg);
   endfunction

   function automatic logic combine(input logic a, input logic b);
      if (C_MODE != 0) return a & b;
      else             return a | b;
   endfunction

   logic             en;
   logic             accept;
   logic [PAD_W-1:0] padded;
   logic             fin_vld;
   logic             fin_res;
   logic             fin_last;
   logic             acc;

   assign en      = ~M_VALID | M_READY;
   assign S_READY = en & ~ARESET;
   assign accept  = S_VALID & S_READY;

   // Pad the top segment with the identity value so it cannot change the result.
   always_comb begin
      padded              = {PAD_W{IDENT}};
      padded[C_WIDTH-1:0] = S_DATA;
   end

   genvar k;
   for (k = 0; k < NSTAGE; k++) begin : g_stage
      localparam int IN_W = PAD_W - k * C_SEG_WIDTH;
      logic [IN_W-1:0] rest_in;
      logic            carry_in;
      logic            vld_in;
      logic            last_in;
      logic            carry_p;
      logic            vld_p;
      logic            last_p;

      if (k == 0) begin : g_first
         assign rest_in  = padded;
         assign carry_in = IDENT;
         assign vld_in   = accept;
         assign last_in  = S_LAST;
      end else begin : g_next
         assign rest_in  = g_stage[k-1].g_rest.rest_p;
         assign carry_in = g_stage[k-1].carry_p;
         assign vld_in   = g_stage[k-1].vld_p;
         assign last_in  = g_stage[k-1].last_p;
      end

      // ---- stage k boundary: consume the low segment, forward the rest ----
      always_ff @(posedge ACLK) begin
         if (ARESET)  vld_p <= 1'b0;
         else if (en) vld_p <= vld_in;
      end

      always_ff @(posedge ACLK) begin
         if (en && vld_in) begin
            carry_p <= red_seg(carry_in, rest_in[C_SEG_WIDTH-1:0]);
            last_p  <= last_in;
         end
      end

      if (k < NSTAGE - 1) begin : g_rest
         logic [IN_W-C_SEG_WIDTH-1:0] rest_p;
         always_ff @(posedge ACLK) begin
            if (en && vld_in) rest_p <= rest_in[IN_W-1:C_SEG_WIDTH];
         end
      end
   end

   assign fin_vld  = g_stage[NSTAGE-1].vld_p;
   assign fin_res  = g_stage[NSTAGE-1].carry_p;
   assign fin_last = g_stage[NSTAGE-1].last_p;

   // ---- output boundary: per-beat result or per-burst accumulation ----
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         M_VALID  <= 1'b0;
         M_RESULT <= 1'b0;
         acc      <= IDENT;
      end else if (en) begin
         if (C_ACCUM == 0) begin
            M_VALID <= fin_vld;
            if (fin_vld) M_RESULT <= fin_res;
         end else begin
            M_VALID <= fin_vld & fin_last;
            if (fin_vld) begin
               if (fin_last) begin
                  M_RESULT <= combine(acc, fin_res);
                  acc      <= IDENT;
               end else begin
                  acc <= combine(acc, fin_res);
               end
            end
         end
      end
   end

endmodule
